// File: rtl/ysyx_25010008_axil_sram.sv
// AXI4-Lite slave backed by a word-addressed storage array, with configurable
// read and write latency. Read and write channels run independently.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_WAIT | address latched, counting down the remaining read latency
// R_RESP | rvalid high with rdata/rresp held until rready
// W_IDLE | awready/wready high until each channel has been latched
// W_WAIT | address and data latched, counting down the remaining write latency
// W_RESP | memory committed, bvalid held until bready
module ysyx_25010008_axil_sram #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          RD_LAT     = 2,
    parameter int          WR_LAT     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
    localparam logic [3:0]  RD_LOAD = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
    localparam logic [3:0]  WR_LOAD = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    r_state_t    r_state;
    w_state_t    w_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt;
    logic [31:0] ar_q;
    logic [31:0] aw_q;
    logic [31:0] wd_q;
    logic [3:0]  ws_q;

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return {1'b0, off} < SPAN;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return DEPTH_LOG2'(off >> 2);
    endfunction

    logic [31:0] rd_addr;
    logic        rd_hit;
    logic [31:0] rd_word;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_have;
    logic        w_have;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_hit;
    logic        commit;

    // Sampling happens either straight from the bus (RD_LAT=1) or from the latched address.
    always_comb begin
        rd_addr = (r_state == R_IDLE) ? araddr : ar_q;
        rd_hit  = in_range(rd_addr);
        rd_word = rd_hit ? mem[word_idx(rd_addr)] : 32'h0;
    end

    always_comb begin
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        aw_have = aw_hs || !awready;
        w_have  = w_hs || !wready;
        wr_addr = aw_hs ? awaddr : aw_q;
        wr_data = w_hs ? wdata : wd_q;
        wr_strb = w_hs ? wstrb : ws_q;
        wr_hit  = in_range(wr_addr);
        commit  = 1'b0;
        if (!reset) begin
            if (w_state == W_IDLE)
                commit = aw_have && w_have && (WR_LAT == 1);
            else if (w_state == W_WAIT)
                commit = (w_cnt == 4'd0);
        end
    end

    // Storage is not reset so contents survive a mid-transaction reset.
    always_ff @(posedge clock) begin
        if (commit && wr_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i])
                    mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= 32'h0;
            rresp   <= OKAY;
            r_cnt   <= 4'd0;
            ar_q    <= 32'h0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        ar_q    <= araddr;
                        arready <= 1'b0;
                        if (RD_LAT == 1) begin
                            rdata   <= rd_word;
                            rresp   <= rd_hit ? OKAY : SLVERR;
                            rvalid  <= 1'b1;
                            r_state <= R_RESP;
                        end else begin
                            r_cnt   <= RD_LOAD;
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        rdata   <= rd_word;
                        rresp   <= rd_hit ? OKAY : SLVERR;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            w_cnt   <= 4'd0;
            aw_q    <= 32'h0;
            wd_q    <= 32'h0;
            ws_q    <= 4'h0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_q    <= awaddr;
                        awready <= 1'b0;
                    end
                    if (w_hs) begin
                        wd_q   <= wdata;
                        ws_q   <= wstrb;
                        wready <= 1'b0;
                    end
                    if (aw_have && w_have) begin
                        if (WR_LAT == 1) begin
                            bresp   <= wr_hit ? OKAY : SLVERR;
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt   <= WR_LOAD;
                            w_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd0) begin
                        bresp   <= wr_hit ? OKAY : SLVERR;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule
